// File: rtl/gp_reg_bank.sv
// gp_reg_bank: general-purpose register bank for the down-sampling datapath.
// DEPTH registers of WIDTH bits.
// Each register supports write, clear and increment with a wrap flag.
// A separate low-order field insert port writes bits [FIELD_W-1:0].
// There are two combinational read ports.
// All state changes on the falling edge of i_clk.
// Reset (i_rst) is synchronous and active-high.
// Optional build macro REG_SWAP_EN adds input i_swp. When op is nop and
// i_swp is high, reg[wr_sel] and reg[rd_sel_b] exchange contents.
module gp_reg_bank #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int FIELD_W = 2,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [1:0]         i_op,
    input  logic [AW-1:0]      i_wr_sel,
    input  logic [WIDTH-1:0]   i_wr_data,
    input  logic               i_fld_en,
    input  logic [AW-1:0]      i_fld_sel,
    input  logic [FIELD_W-1:0] i_fld_data,
`ifdef REG_SWAP_EN
    input  logic               i_swp,
`endif
    input  logic [AW-1:0]      i_rd_sel_a,
    input  logic [AW-1:0]      i_rd_sel_b,
    output logic [WIDTH-1:0]   o_rd_data_a,
    output logic [WIDTH-1:0]   o_rd_data_b,
    output logic               o_inc_wrap,
    output logic               o_zero
);

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_CLEAR = 2'b10,
        OP_INC   = 2'b11
    } op_e;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic             r_inc_wrap;
    logic             r_zero;

    logic [WIDTH-1:0] w_next [DEPTH];
    logic [WIDTH-1:0] w_old_wr;
    logic             w_swap_active;
    logic             w_wrap_next;
    logic             w_zero_update;
    op_e              w_op;

    assign w_op     = op_e'(i_op);
    assign w_old_wr = r_regs[i_wr_sel];

`ifdef REG_SWAP_EN
    assign w_swap_active = i_swp && (w_op == OP_NOP);
`else
    assign w_swap_active = 1'b0;
`endif

    // The wrap pulse comes only from an increment of an all-ones value.
    // The field overwrite does not affect it.
    assign w_wrap_next = (w_op == OP_INC) && (&w_old_wr);

    // zero tracks the last op that actually targeted wr_sel. A swap counts
    // as such an op.
    assign w_zero_update = (w_op != OP_NOP) || w_swap_active;

    // Next-state image of the whole bank.
    // The op (or swap) is applied first. The field insert is applied next,
    // so its low bits win over the op result.
    always_comb begin
        w_next = r_regs;
        unique case (w_op)
            OP_WRITE: w_next[i_wr_sel] = i_wr_data;
            OP_CLEAR: w_next[i_wr_sel] = '0;
            OP_INC:   w_next[i_wr_sel] = w_old_wr + ONE;
            default:  ;
        endcase
        if (w_swap_active) begin
            w_next[i_wr_sel]   = r_regs[i_rd_sel_b];
            w_next[i_rd_sel_b] = w_old_wr;
        end
        if (i_fld_en) begin
            w_next[i_fld_sel][FIELD_W-1:0] = i_fld_data;
        end
    end

    // Commit the bank on the falling edge. Reset clears everything and
    // overrides any op, swap or field insert in the same cycle.
    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_regs <= w_next;
        end
    end

    // Status flags: the wrap flag is a single-edge pulse. zero holds its
    // value across nops.
    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            r_inc_wrap <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            r_inc_wrap <= w_wrap_next;
            if (w_zero_update) begin
                r_zero <= (w_next[i_wr_sel] == '0);
            end
        end
    end

    assign o_rd_data_a = r_regs[i_rd_sel_a];
    assign o_rd_data_b = r_regs[i_rd_sel_b];
    assign o_inc_wrap  = r_inc_wrap;
    assign o_zero      = r_zero;

endmodule

// File: doc/gp_reg_bank.md
Name: gp_reg_bank

Overview:
Parametrised general-purpose register bank for the down-sampling datapath. It generalises the single 8-bit write/clear/field-insert register to DEPTH registers of WIDTH bits. It adds a per-register increment with a wrap flag and two combinational read ports. It sits between the control unit and the ALU/memory buses and holds pixel data, address pointers and loop counters.

Parameters:
WIDTH, 8, register width in bits (>= FIELD_W, >= 2)
DEPTH, 8, number of registers (power of 2, >= 2)
FIELD_W, 2, width of the low-order field-insert port (>= 1)
AW, $clog2(DEPTH), register address width (derived)

Ports:
clk  in  1  clock; all state updates on the falling edge
rst  in  1  reset, synchronous, active-high
op  in  2  operation on register wr_sel: 00 nop, 01 write, 10 clear, 11 increment
wr_sel  in  AW  target register for op
wr_data  in  WIDTH  write data (bus3 equivalent)
fld_en  in  1  field insert enable
fld_sel  in  AW  target register for field insert
fld_data  in  FIELD_W  data inserted into bits [FIELD_W-1:0] (bus5 equivalent)
rd_sel_a  in  AW  read port A address
rd_sel_b  in  AW  read port B address
rd_data_a  out  WIDTH  contents of reg[rd_sel_a], combinational
rd_data_b  out  WIDTH  contents of reg[rd_sel_b], combinational
inc_wrap  out  1  registered one-cycle pulse: last increment wrapped all-ones to zero
zero  out  1  registered: result written to wr_sel by last non-nop op is zero

Behaviour:
- Reset: rst high at a falling edge sets all registers to 0, inc_wrap to 0 and zero to 0. Reset overrides op, field insert and swap in that cycle.
- All updates happen on the falling edge. Read ports show the new value after that edge. There is no write-through bypass within a cycle.
- op=01: reg[wr_sel] <= wr_data.
- op=10: reg[wr_sel] <= 0.
- op=11: reg[wr_sel] <= reg[wr_sel] + 1, modulo 2^WIDTH. inc_wrap <= 1 only if the old value was all ones.
- inc_wrap is 0 at every edge where op != 11 or no wrap occurs. It is a pulse, not sticky.
- zero: updated on every non-nop op to (resulting full register value == 0), evaluated after any field insert to the same register. It holds its value on nop.
- Field insert: with fld_en=1, reg[fld_sel][FIELD_W-1:0] <= fld_data and the upper bits are unchanged. It is applied after op in the same cycle.
  - If fld_sel == wr_sel, the low FIELD_W bits come from fld_data and the upper bits come from the op result (write, clear or increment).
  - inc_wrap still reflects the increment wrap condition, independent of the field overwrite.
- Field insert and op to different registers in the same cycle both take effect.
- Out-of-range addresses cannot occur, because DEPTH is a power of 2.
- No internal state beyond the registers, inc_wrap and zero. There is no multi-cycle latency: every op completes in one edge.

Optional Feature:
Macro REG_SWAP_EN.
- Defined:
  - Adds input swp (1 bit). With swp=1 and op=00, reg[wr_sel] and reg[rd_sel_b] exchange contents at the falling edge.
  - swp with op != 00 is ignored.
  - swp with wr_sel == rd_sel_b leaves the register unchanged.
  - Field insert applies after the swap.
  - zero is updated from the new reg[wr_sel].
- Not defined: no swp port. op=00 is a pure nop.

Test Plan:
- Reset/write: rst=1 for 2 edges, then op=01 wr_sel=3 wr_data=0xA5 -> rd_data_a (sel 3)=0xA5, zero=0. Then rst=1 -> all reads 0, zero=0, inc_wrap=0.
- Increment wrap: write reg2=0xFE, then op=11 twice.
  - First edge: reg2=0xFF, inc_wrap=0.
  - Second edge: reg2=0x00, inc_wrap=1, zero=1.
  - Next nop edge: inc_wrap=0, zero=1.
- Field insert combined: reg5=0x3C. op=01 wr_sel=5 wr_data=0x80 with fld_en=1 fld_sel=5 fld_data=2'b11 -> reg5=0x83. Separate cycle fld_en only, fld_data=2'b01 -> reg5=0x81.
- Clear plus field: op=10 wr_sel=1 with fld_en=1 fld_sel=1 fld_data=2'b10 -> reg1=0x02, zero=0. Concurrent op=01 to reg0 and fld_en to reg7 -> both updated.
- Read ports: rd_sel_a=rd_sel_b=4 after writing 0x5A -> both outputs 0x5A. rst asserted in the same cycle as op=01 -> register stays 0.
- REG_SWAP_EN build: reg0=0x11, reg6=0x22, swp=1 op=00 wr_sel=0 rd_sel_b=6 -> reg0=0x22, reg6=0x11. swp=1 with op=01 -> write only, no swap.
